// File: rtl/lcg_stim_pkg.sv
// Shared types and constants for the LCG stimulus generator.
// Holds the mode/state encodings, the harness LCG constants and the
// word-count helper used to size the vector assembly path.
package lcg_stim_pkg;

  typedef enum logic [1:0] {
    MODE_RANDOM     = 2'd0,
    MODE_INCR       = 2'd1,
    MODE_WALK1      = 2'd2,
    MODE_RANDOM_ALT = 2'd3   // behaves exactly like MODE_RANDOM
  } mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GEN     = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [31:0] LCG_SEED_DEF = 32'd362960400;
  localparam logic [31:0] LCG_MULT_DEF = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC_DEF  = 32'h00003039;

  // Number of 32-bit words needed to cover a w-bit vector.
  function automatic int unsigned nwords(input int unsigned w);
    return (w + 31) / 32;
  endfunction

  // One LCG step, arithmetic modulo 2^32.
  function automatic logic [31:0] lcg_next(input logic [31:0] x,
                                           input logic [31:0] mult = LCG_MULT_DEF,
                                           input logic [31:0] inc  = LCG_INC_DEF);
    return x * mult + inc;
  endfunction

endpackage

// File: rtl/lcg_core.sv
// 32-bit LCG state register; zero latency from state to nxt, one step per advance.
// No handshake: the caller decides when to load or advance.
// Ports: clk, rst (async high) | load + seed_in replace the state | advance steps it |
//        nxt is the value the state takes on the next advance.
module lcg_core
  import lcg_stim_pkg::*;
#(
  parameter logic [31:0] SEED = LCG_SEED_DEF,
  parameter logic [31:0] MULT = LCG_MULT_DEF,
  parameter logic [31:0] INC  = LCG_INC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed_in,
  input  logic        advance,
  output logic [31:0] nxt
);

  logic [31:0] x;

  assign nxt = lcg_next(x, MULT, INC);

  // load wins over advance; the top never asserts both together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= SEED;
    end else if (load) begin
      x <= seed_in;
    end else if (advance) begin
      x <= nxt;
    end
  end

endmodule

// File: rtl/lcg_stim_gen.sv
// Stimulus source: RANDOM (LCG), INCR and WALK1 vectors of OUT_W bits.
// Latency: NWORDS cycles to build a vector, then held until taken; max one vector per NWORDS+1 cycles.
// Backpressure: stim_data/stim_valid hold stable while stim_ready is low; nothing is generated meanwhile.
// Ports: clk, rst (async high) | seed_load/seed_in, mode, num_vec, start, stop (run control) |
//        stim_data/stim_valid/stim_ready (vector handshake) | busy, done, vec_count (status).
module lcg_stim_gen
  import lcg_stim_pkg::*;
#(
  parameter int unsigned OUT_W = 139,
  parameter logic [31:0] SEED  = LCG_SEED_DEF,
  parameter logic [31:0] MULT  = LCG_MULT_DEF,
  parameter logic [31:0] INC   = LCG_INC_DEF,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [31:0]      seed_in,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             start,
  input  logic             stop,
  output logic [OUT_W-1:0] stim_data,
  output logic             stim_valid,
  input  logic             stim_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_count
);

  localparam int unsigned NW    = nwords(OUT_W);
  localparam int unsigned ASM_W = NW * 32;
  localparam int unsigned WI_W  = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [WI_W-1:0] LAST_WORD = WI_W'(NW - 1);

  state_e           state;
  logic [WI_W-1:0]  word_idx;
  logic [ASM_W-1:0] asm_q;
  logic [ASM_W-1:0] asm_next;
  mode_e            mode_q;
  logic [CNT_W-1:0] num_vec_q;

  logic [31:0]      lcg_nxt;
  logic             lcg_load;
  logic             lcg_adv;
  logic             is_random;
  logic [31:0]      gen_word;
  logic [ASM_W-1:0] incr_vec;
  logic [ASM_W-1:0] walk_vec;
  logic [IDX_W-1:0] walk_idx;
  logic [CNT_W-1:0] count_inc;

  assign is_random = (mode_q != MODE_INCR) && (mode_q != MODE_WALK1);
  assign lcg_load  = seed_load && ((state == IDLE) || (state == DONE));
  // A stop cycle must not consume an LCG value.
  assign lcg_adv   = (state == GEN) && !stop && is_random;
  assign busy      = (state == GEN) || (state == PRESENT);
  assign count_inc = vec_count + CNT_W'(1);

  lcg_core #(
    .SEED (SEED),
    .MULT (MULT),
    .INC  (INC)
  ) u_lcg (
    .clk     (clk),
    .rst     (rst),
    .load    (lcg_load),
    .seed_in (seed_in),
    .advance (lcg_adv),
    .nxt     (lcg_nxt)
  );

  // INCR and WALK1 are derived from the count of vectors already transferred.
  assign incr_vec = ASM_W'(vec_count);
  assign walk_idx = IDX_W'(vec_count % CNT_W'(OUT_W));
  assign walk_vec = ASM_W'(1) << walk_idx;

  always_comb begin
    gen_word = lcg_nxt;
    case (mode_q)
      MODE_INCR:  gen_word = incr_vec[32*int'(word_idx) +: 32];
      MODE_WALK1: gen_word = walk_vec[32*int'(word_idx) +: 32];
      default:    gen_word = lcg_nxt;
    endcase
  end

  // Merge the word being generated this cycle so the last word can go
  // straight into stim_data without an extra cycle.
  always_comb begin
    asm_next = asm_q;
    asm_next[32*int'(word_idx) +: 32] = gen_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word_idx   <= '0;
      asm_q      <= '0;
      stim_data  <= '0;
      stim_valid <= 1'b0;
      done       <= 1'b0;
      vec_count  <= '0;
      mode_q     <= MODE_RANDOM;
      num_vec_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= GEN;
            word_idx  <= '0;
            mode_q    <= mode_e'(mode);
            num_vec_q <= num_vec;
            vec_count <= '0;
            done      <= 1'b0;
          end
        end
        GEN: begin
          if (stop) begin
            state <= IDLE;
          end else begin
            asm_q <= asm_next;
            if (word_idx == LAST_WORD) begin
              stim_data  <= asm_next[OUT_W-1:0];
              stim_valid <= 1'b1;
              state      <= PRESENT;
            end else begin
              word_idx <= word_idx + WI_W'(1);
            end
          end
        end
        PRESENT: begin
          // stop outranks a same-cycle transfer: the vector is dropped uncounted.
          if (stop) begin
            state      <= IDLE;
            stim_valid <= 1'b0;
          end else if (stim_ready) begin
            vec_count  <= count_inc;
            stim_valid <= 1'b0;
            if ((num_vec_q != '0) && (count_inc == num_vec_q)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= GEN;
              word_idx <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
